regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (WE3/A3/WD3) between two writeback requesters: A = ALU result path, B = memory-load path.
- Each requester has a valid/ready handshake and a one-entry holding buffer.
- A round-robin arbiter issues one write per cycle through a registered write port.
- Publishes a busy mask of registers with pending writes, so decode can stall on read-after-write.

---
 rtl/regfile_write_arbiter.sv | 173 +++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port (WE3/A3/WD3).
// Optional REGFILE_WRITE_R15_BLOCK_EN: writes to the top register are acknowledged but dropped.
//
// buffer state | meaning
// EMPTY        | no write held; requester may hand one over
// FULL         | one write held, waiting for (or receiving) a grant
module regfile_write_arbiter #(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [N-1:0]      a_addr,
  input  logic [M-1:0]      a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [N-1:0]      b_addr,
  input  logic [M-1:0]      b_data,
  output logic              WE3,
  output logic [N-1:0]      A3,
  output logic [M-1:0]      WD3,
  output logic [2**N-1:0]   busy_mask
`ifdef REGFILE_WRITE_R15_BLOCK_EN
  ,
  output logic              r15_drop
`endif
);

  localparam int R = 2**N;
  localparam logic [R-1:0] ONE_HOT0 = {{(R-1){1'b0}}, 1'b1};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  buf_state_t a_state_q, a_state_d, b_state_q, b_state_d;
  logic [N-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [M-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic         last_b_q, last_b_d;
  logic         we3_q, we3_d;
  logic [N-1:0] a3_q, a3_d;
  logic [M-1:0] wd3_q, wd3_d;

  logic a_full, b_full, a_r15, b_r15;
  logic elig_a, elig_b, drop_a, drop_b;
  logic grant_a, grant_b, accept_a, accept_b;

`ifdef REGFILE_WRITE_R15_BLOCK_EN
  localparam logic [N-1:0] R15_ADDR = '1;
  logic r15_drop_q, r15_drop_d;
`endif

  always_comb begin
    a_full = (a_state_q == FULL);
    b_full = (b_state_q == FULL);
    a_r15  = 1'b0;
    b_r15  = 1'b0;
`ifdef REGFILE_WRITE_R15_BLOCK_EN
    a_r15  = (a_addr_q == R15_ADDR);
    b_r15  = (b_addr_q == R15_ADDR);
`endif
    elig_a = a_full && !a_r15;
    elig_b = b_full && !b_r15;
    // Only one drop per cycle so r15_drop pulses once per discarded write.
    drop_a = a_full && a_r15;
    drop_b = b_full && b_r15 && !drop_a;
    grant_a  = elig_a && (!elig_b || last_b_q);
    grant_b  = elig_b && !grant_a;
    a_ready  = !a_full || grant_a || drop_a;
    b_ready  = !b_full || grant_b || drop_b;
    accept_a = a_valid && a_ready;
    accept_b = b_valid && b_ready;
  end

  always_comb begin
    a_state_d = a_state_q;
    a_addr_d  = a_addr_q;
    a_data_d  = a_data_q;
    if (accept_a) begin
      a_state_d = FULL;
      a_addr_d  = a_addr;
      a_data_d  = a_data;
    end else if (grant_a || drop_a) begin
      a_state_d = EMPTY;
      a_addr_d  = '0;
      a_data_d  = '0;
    end
  end

  always_comb begin
    b_state_d = b_state_q;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    if (accept_b) begin
      b_state_d = FULL;
      b_addr_d  = b_addr;
      b_data_d  = b_data;
    end else if (grant_b || drop_b) begin
      b_state_d = EMPTY;
      b_addr_d  = '0;
      b_data_d  = '0;
    end
  end

  always_comb begin
    we3_d    = grant_a || grant_b;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    last_b_d = last_b_q;
    if (grant_a) begin
      a3_d     = a_addr_q;
      wd3_d    = a_data_q;
      last_b_d = 1'b0;
    end else if (grant_b) begin
      a3_d     = b_addr_q;
      wd3_d    = b_data_q;
      last_b_d = 1'b1;
    end
  end

`ifdef REGFILE_WRITE_R15_BLOCK_EN
  always_comb begin
    r15_drop_d = drop_a || drop_b;
  end
`endif

  always_comb begin
    busy_mask = '0;
    if (elig_a) busy_mask = busy_mask | (ONE_HOT0 << a_addr_q);
    if (elig_b) busy_mask = busy_mask | (ONE_HOT0 << b_addr_q);
    if (we3_q)  busy_mask = busy_mask | (ONE_HOT0 << a3_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_state_q <= EMPTY;
      b_state_q <= EMPTY;
      a_addr_q  <= '0;
      a_data_q  <= '0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
      last_b_q  <= 1'b1;
      we3_q     <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
    end else begin
      a_state_q <= a_state_d;
      b_state_q <= b_state_d;
      a_addr_q  <= a_addr_d;
      a_data_q  <= a_data_d;
      b_addr_q  <= b_addr_d;
      b_data_q  <= b_data_d;
      last_b_q  <= last_b_d;
      we3_q     <= we3_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
    end
  end

`ifdef REGFILE_WRITE_R15_BLOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r15_drop_q <= 1'b0;
    else        r15_drop_q <= r15_drop_d;
  end

  assign r15_drop = r15_drop_q;
`endif

  assign WE3 = we3_q;
  assign A3  = a3_q;
  assign WD3 = wd3_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default N=4, M=32).
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [3:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        WE3;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic [15:0] busy_mask;
`ifdef REGFILE_WRITE_R15_BLOCK_EN
  logic        r15_drop;
`endif

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.N(4), .M(32)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .WE3(WE3), .A3(A3), .WD3(WD3), .busy_mask(busy_mask)
`ifdef REGFILE_WRITE_R15_BLOCK_EN
    , .r15_drop(r15_drop)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got=%0h exp=0", WE3); end
    checks++; if (A3 !== 4'h0) begin errors++; $display("FAIL reset_a3 got=%0h exp=0", A3); end
    checks++; if (WD3 !== 32'h0) begin errors++; $display("FAIL reset_wd3 got=%0h exp=0", WD3); end
    checks++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy_mask); end
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", a_ready, b_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write;
    do_reset();
    a_valid = 1'b1; a_addr = 4'd3; a_data = 32'h0000_00AA;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", a_ready); end
    tick();
    a_valid = 1'b0;
    checks++; if (WE3 !== 1'b0 || busy_mask !== 16'h0008) begin errors++; $display("FAIL single_k1 got we3=%b busy=%0h exp we3=0 busy=8", WE3, busy_mask); end
    tick();
    checks++; if (WE3 !== 1'b1 || A3 !== 4'd3 || WD3 !== 32'hAA) begin errors++; $display("FAIL single_k2 got we3=%b a3=%0h wd3=%0h exp 1/3/aa", WE3, A3, WD3); end
    checks++; if (busy_mask !== 16'h0008) begin errors++; $display("FAIL single_k2_busy got=%0h exp=8", busy_mask); end
    tick();
    checks++; if (WE3 !== 1'b0 || busy_mask !== 16'h0 || A3 !== 4'd3 || WD3 !== 32'hAA) begin errors++; $display("FAIL single_k3 got we3=%b busy=%0h a3=%0h wd3=%0h exp 0/0/3/aa", WE3, busy_mask, A3, WD3); end
  endtask

  task automatic test_conflict;
    do_reset();
    a_valid = 1'b1; a_addr = 4'd1; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 32'h22;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (b_ready !== 1'b0 || a_ready !== 1'b1) begin errors++; $display("FAIL conflict_ready got a=%b b=%b exp a=1 b=0", a_ready, b_ready); end
    checks++; if (busy_mask !== 16'h0006 || WE3 !== 1'b0) begin errors++; $display("FAIL conflict_k1 got busy=%0h we3=%b exp 6/0", busy_mask, WE3); end
    tick();
    checks++; if (WE3 !== 1'b1 || A3 !== 4'd1 || WD3 !== 32'h11) begin errors++; $display("FAIL conflict_a got we3=%b a3=%0h wd3=%0h exp 1/1/11", WE3, A3, WD3); end
    checks++; if (busy_mask !== 16'h0006) begin errors++; $display("FAIL conflict_k2_busy got=%0h exp=6", busy_mask); end
    tick();
    checks++; if (WE3 !== 1'b1 || A3 !== 4'd2 || WD3 !== 32'h22) begin errors++; $display("FAIL conflict_b got we3=%b a3=%0h wd3=%0h exp 1/2/22", WE3, A3, WD3); end
    checks++; if (busy_mask !== 16'h0004) begin errors++; $display("FAIL conflict_k3_busy got=%0h exp=4", busy_mask); end
    tick();
    checks++; if (WE3 !== 1'b0 || busy_mask !== 16'h0) begin errors++; $display("FAIL conflict_k4 got we3=%b busy=%0h exp 0/0", WE3, busy_mask); end
  endtask

  task automatic test_fairness;
    int a_cnt;
    int b_cnt;
    logic [3:0]  exp_a3;
    logic [31:0] exp_wd3;
    do_reset();
    a_cnt = 0; b_cnt = 0;
    a_valid = 1'b1; a_addr = 4'd4;
    b_valid = 1'b1; b_addr = 4'd6;
    for (int c = 0; c < 10; c++) begin
      a_data = 32'hA000_0000 + 32'(a_cnt);
      b_data = 32'hB000_0000 + 32'(b_cnt);
      if (c >= 1) begin
        checks++;
        if (a_ready !== 1'((c % 2) == 1) || b_ready !== 1'((c % 2) == 0)) begin
          errors++; $display("FAIL fair_ready c=%0d got a=%b b=%b exp a=%b", c, a_ready, b_ready, 1'((c % 2) == 1));
        end
      end
      if (c >= 2) begin
        if ((c % 2) == 0) begin exp_a3 = 4'd4; exp_wd3 = 32'hA000_0000 + 32'((c - 2) / 2); end
        else begin exp_a3 = 4'd6; exp_wd3 = 32'hB000_0000 + 32'((c - 3) / 2); end
        checks++;
        if (WE3 !== 1'b1 || A3 !== exp_a3 || WD3 !== exp_wd3) begin
          errors++; $display("FAIL fair_write c=%0d got we3=%b a3=%0h wd3=%0h exp 1/%0h/%0h", c, WE3, A3, WD3, exp_a3, exp_wd3);
        end
      end
      if (a_ready) a_cnt++;
      if (b_ready) b_cnt++;
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) tick();
    checks++; if (WE3 !== 1'b0 || busy_mask !== 16'h0) begin errors++; $display("FAIL fair_drain got we3=%b busy=%0h exp 0/0", WE3, busy_mask); end
  endtask

  task automatic test_same_address;
    do_reset();
    a_valid = 1'b1; a_addr = 4'd5; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 4'd5; b_data = 32'h2;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (busy_mask !== 16'h0020) begin errors++; $display("FAIL same_k1_busy got=%0h exp=20", busy_mask); end
    tick();
    checks++; if (WE3 !== 1'b1 || A3 !== 4'd5 || WD3 !== 32'h1 || busy_mask !== 16'h0020) begin errors++; $display("FAIL same_first got we3=%b a3=%0h wd3=%0h busy=%0h exp 1/5/1/20", WE3, A3, WD3, busy_mask); end
    tick();
    checks++; if (WE3 !== 1'b1 || A3 !== 4'd5 || WD3 !== 32'h2 || busy_mask !== 16'h0020) begin errors++; $display("FAIL same_second got we3=%b a3=%0h wd3=%0h busy=%0h exp 1/5/2/20", WE3, A3, WD3, busy_mask); end
    tick();
    checks++; if (WE3 !== 1'b0 || busy_mask !== 16'h0 || WD3 !== 32'h2) begin errors++; $display("FAIL same_done got we3=%b busy=%0h wd3=%0h exp 0/0/2", WE3, busy_mask, WD3); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      a_valid = (c < 8);
      a_addr  = 4'(c);
      a_data  = 32'hC000_0000 + 32'(c);
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d got a=%b b=%b exp 1/1", c, a_ready, b_ready); end
      if (c >= 2) begin
        checks++;
        if (WE3 !== 1'b1 || A3 !== 4'(c - 2) || WD3 !== 32'hC000_0000 + 32'(c - 2)) begin
          errors++; $display("FAIL b2b_write c=%0d got we3=%b a3=%0h wd3=%0h exp 1/%0h/%0h", c, WE3, A3, WD3, 4'(c - 2), 32'hC000_0000 + 32'(c - 2));
        end
      end
      tick();
    end
    checks++; if (WE3 !== 1'b0 || busy_mask !== 16'h0) begin errors++; $display("FAIL b2b_end got we3=%b busy=%0h exp 0/0", WE3, busy_mask); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    a_valid = 1'b1; a_addr = 4'd7; a_data = 32'h77;
    b_valid = 1'b1; b_addr = 4'd8; b_data = 32'h88;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    checks++; if (WE3 !== 1'b1 || busy_mask !== 16'h0180) begin errors++; $display("FAIL mid_pre got we3=%b busy=%0h exp 1/180", WE3, busy_mask); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (WE3 !== 1'b0 || busy_mask !== 16'h0 || A3 !== 4'h0 || WD3 !== 32'h0) begin errors++; $display("FAIL mid_clear got we3=%b busy=%0h a3=%0h wd3=%0h exp 0/0/0/0", WE3, busy_mask, A3, WD3); end
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got a=%b b=%b exp 1/1", a_ready, b_ready); end
    #2;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (WE3 !== 1'b0 || busy_mask !== 16'h0) begin errors++; $display("FAIL mid_stale c=%0d got we3=%b busy=%0h exp 0/0", c, WE3, busy_mask); end
    end
  endtask

`ifdef REGFILE_WRITE_R15_BLOCK_EN
  task automatic test_r15_block;
    do_reset();
    a_valid = 1'b1; a_addr = 4'd15; a_data = 32'h0000_DEAD;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL r15_ready got=%b exp=1", a_ready); end
    tick();
    a_valid = 1'b0;
    checks++; if (WE3 !== 1'b0 || busy_mask !== 16'h0 || r15_drop !== 1'b0) begin errors++; $display("FAIL r15_k1 got we3=%b busy=%0h drop=%b exp 0/0/0", WE3, busy_mask, r15_drop); end
    tick();
    checks++; if (WE3 !== 1'b0 || busy_mask !== 16'h0 || r15_drop !== 1'b1 || a_ready !== 1'b1) begin errors++; $display("FAIL r15_k2 got we3=%b busy=%0h drop=%b rdy=%b exp 0/0/1/1", WE3, busy_mask, r15_drop, a_ready); end
    tick();
    checks++; if (WE3 !== 1'b0 || r15_drop !== 1'b0) begin errors++; $display("FAIL r15_k3 got we3=%b drop=%b exp 0/0", WE3, r15_drop); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_conflict();
    test_fairness();
    test_same_address();
    test_back_to_back();
    test_reset_mid();
`ifdef REGFILE_WRITE_R15_BLOCK_EN
    test_r15_block();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
